control_unit: RTL



---
 rtl/k_and_s_pkg.sv | 49 ++++
 rtl/control_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/k_and_s_pkg.sv
// Shared K&S processor types: decoded instruction codes, control FSM states and ALU opcodes.
package k_and_s_pkg;

    // 5-bit code space leaves 16 codes undefined; control treats those as NOP.
    typedef enum logic [4:0] {
        I_NOP    = 5'd0,
        I_LOAD   = 5'd1,
        I_STORE  = 5'd2,
        I_MOVE   = 5'd3,
        I_ADD    = 5'd4,
        I_SUB    = 5'd5,
        I_AND    = 5'd6,
        I_OR     = 5'd7,
        I_BRANCH = 5'd8,
        I_BZERO  = 5'd9,
        I_BNZERO = 5'd10,
        I_BNEG   = 5'd11,
        I_BNNEG  = 5'd12,
        I_BOV    = 5'd13,
        I_BNOV   = 5'd14,
        I_HALT   = 5'd15
    } decoded_instruction_type;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_LOAD,
        S_STORE,
        S_ALU,
        S_MOVE,
        S_BRANCH,
        S_HALT
    } ctrl_state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_AND = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;
    localparam logic [1:0] ALU_SUB = 2'b11;

    function automatic logic [1:0] alu_op_of(input decoded_instruction_type instr);
        case (instr)
            I_AND:   return ALU_AND;
            I_OR:    return ALU_OR;
            I_SUB:   return ALU_SUB;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_unit.sv
// K&S control FSM: sequences fetch/decode/execute and drives every data_path control strobe.
module control_unit
    import k_and_s_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 0,
    parameter int unsigned ICNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic [1:0]              operation,
    output logic                    write_reg_enable,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic                    halt,
    output logic [ICNT_W-1:0]       instr_count
);

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

    ctrl_state_t             state_q, state_d;
    logic [2:0]              wait_q, wait_d;
    decoded_instruction_type instr_q, instr_d;
    logic [ICNT_W-1:0]       count_q;
    logic                    mem_last;
    logic                    taken;
    logic                    retire;

    // No branch opcode tests the signed-overflow flag.
    logic unused_signed_overflow;
    assign unused_signed_overflow = signed_overflow;

    assign mem_last    = (wait_q == WAIT_LAST);
    assign instr_count = count_q;

    always_comb begin
        taken = 1'b0;
        case (instr_q)
            I_BRANCH: taken = 1'b1;
            I_BZERO:  taken = zero_op;
            I_BNZERO: taken = !zero_op;
            I_BNEG:   taken = neg_op;
            I_BNNEG:  taken = !neg_op;
            I_BOV:    taken = unsigned_overflow;
            I_BNOV:   taken = !unsigned_overflow;
            default:  taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_last) state_d = S_DECODE;
            end
            S_DECODE: begin
                instr_d = decoded_instruction;
                case (decoded_instruction)
                    I_LOAD:  state_d = S_LOAD;
                    I_STORE: state_d = S_STORE;
                    I_ADD, I_SUB, I_AND, I_OR: state_d = S_ALU;
                    I_MOVE:  state_d = S_MOVE;
                    I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV:
                        state_d = S_BRANCH;
                    I_HALT:  state_d = S_HALT;
                    default: begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                endcase
            end
            S_LOAD: begin
                if (mem_last) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_STORE, S_ALU, S_MOVE, S_BRANCH: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
        // Only the memory-wait states dwell; any state change restarts the count.
        if (state_d == state_q && (state_q == S_FETCH || state_q == S_LOAD)) begin
            wait_d = wait_q + 3'd1;
        end else begin
            wait_d = 3'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            wait_q  <= 3'd0;
            instr_q <= I_NOP;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            instr_q <= instr_d;
            if (retire) count_q <= count_q + ICNT_W'(1);
        end
    end

    always_comb begin
        branch           = 1'b0;
        pc_enable        = 1'b0;
        ir_enable        = 1'b0;
        addr_sel         = 1'b0;
        c_sel            = 1'b0;
        operation        = ALU_ADD;
        write_reg_enable = 1'b0;
        flags_reg_enable = 1'b0;
        ram_write_enable = 1'b0;
        halt             = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_enable = mem_last;
                pc_enable = mem_last;
            end
            S_LOAD: begin
                addr_sel         = 1'b1;
                c_sel            = 1'b1;
                write_reg_enable = mem_last;
            end
            S_STORE: begin
                addr_sel         = 1'b1;
                ram_write_enable = 1'b1;
            end
            S_ALU: begin
                operation        = alu_op_of(instr_q);
                write_reg_enable = 1'b1;
                flags_reg_enable = 1'b1;
            end
            S_MOVE: begin
                operation        = ALU_OR;
                write_reg_enable = 1'b1;
            end
            S_BRANCH: begin
                addr_sel  = 1'b1;
                pc_enable = taken;
                branch    = taken;
            end
            S_HALT:  halt = 1'b1;
            default: ;
        endcase
        // Reset state is S_FETCH; keep its strobes quiet while rst is held.
        if (rst) begin
            branch           = 1'b0;
            pc_enable        = 1'b0;
            ir_enable        = 1'b0;
            write_reg_enable = 1'b0;
            flags_reg_enable = 1'b0;
            ram_write_enable = 1'b0;
        end
    end

endmodule
